// File: rtl/stencil_access_ctrl.sv
// Sequences single-bit read / write / test-and-set requests and a bulk clear
// onto a 1-bit synchronous stencil RAM with separate read and write address ports.
module stencil_access_ctrl #(
    parameter int unsigned ADDR_W = 14
) (
    input  logic              clk,
    input  logic              nRst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [1:0]        req_op,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic              req_data,
    output logic              rsp_valid,
    output logic              rsp_data,
    input  logic              clear_start,
    input  logic              clear_value,
    output logic              clear_busy,
    output logic [ADDR_W-1:0] ram_addrIn,
    output logic [ADDR_W-1:0] ram_addrOut,
    output logic              ram_dataIn,
    input  logic              ram_dataOut,
    output logic              ram_cs,
    output logic              ram_we
);

    localparam int unsigned CNT_W = ADDR_W + 1;

    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_TAS   = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR,
        S_RD,
        S_CAP,
        S_TASW,
        S_CLR
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              tas_q, tas_d;
    logic              clr_val_q, clr_val_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CNT_W-1:0]  cnt_inc;
    logic              cs_q, cs_d;
    logic              we_q, we_d;
    logic              din_q, din_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic              rsp_data_q, rsp_data_d;
    logic              busy_q, busy_d;

    // Both RAM address ports carry the one latched address; cs/we decide the access.
    assign ram_addrIn  = addr_q;
    assign ram_addrOut = addr_q;
    assign ram_dataIn  = din_q;
    assign ram_cs      = cs_q;
    assign ram_we      = we_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_data    = rsp_data_q;
    assign clear_busy  = busy_q;
    assign req_ready   = nRst && (state_q == S_IDLE);

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        tas_d       = tas_q;
        clr_val_d   = clr_val_q;
        cnt_d       = cnt_q;
        cs_d        = cs_q;
        we_d        = we_q;
        din_d       = din_q;
        rsp_valid_d = 1'b0;
        rsp_data_d  = rsp_data_q;
        busy_d      = busy_q;
        cnt_inc     = cnt_q + CNT_W'(1);

        case (state_q)
            S_IDLE: begin
                cs_d = 1'b0;
                we_d = 1'b0;
                // A clear request takes priority; a concurrent request stays pending.
                if (clear_start) begin
                    clr_val_d = clear_value;
                    cnt_d     = '0;
                    addr_d    = '0;
                    cs_d      = 1'b1;
                    we_d      = 1'b1;
                    din_d     = clear_value;
                    busy_d    = 1'b1;
                    state_d   = S_CLR;
                end else if (req_valid) begin
                    addr_d = req_addr;
                    tas_d  = (req_op == OP_TAS);
                    cs_d   = 1'b1;
                    if (req_op == OP_WRITE) begin
                        we_d    = 1'b1;
                        din_d   = req_data;
                        state_d = S_WR;
                    end else begin
                        we_d    = 1'b0;
                        state_d = S_RD;
                    end
                end
            end
            S_WR: begin
                cs_d        = 1'b0;
                we_d        = 1'b0;
                rsp_valid_d = 1'b1;
                rsp_data_d  = 1'b0;
                state_d     = S_IDLE;
            end
            S_RD: begin
                cs_d    = 1'b0;
                we_d    = 1'b0;
                state_d = S_CAP;
            end
            S_CAP: begin
                rsp_valid_d = 1'b1;
                rsp_data_d  = ram_dataOut;
                // Test-and-set writes the 1 back before any other request may enter.
                if (tas_q) begin
                    cs_d    = 1'b1;
                    we_d    = 1'b1;
                    din_d   = 1'b1;
                    state_d = S_TASW;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_TASW: begin
                cs_d    = 1'b0;
                we_d    = 1'b0;
                state_d = S_IDLE;
            end
            S_CLR: begin
                cnt_d = cnt_inc;
                din_d = clr_val_q;
                // Extra counter bit flags that the last address has just been written.
                if (cnt_inc[ADDR_W]) begin
                    cs_d    = 1'b0;
                    we_d    = 1'b0;
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end else begin
                    addr_d = cnt_inc[ADDR_W-1:0];
                end
            end
            default: begin
                cs_d    = 1'b0;
                we_d    = 1'b0;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            tas_q       <= 1'b0;
            clr_val_q   <= 1'b0;
            cnt_q       <= '0;
            cs_q        <= 1'b0;
            we_q        <= 1'b0;
            din_q       <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            tas_q       <= tas_d;
            clr_val_q   <= clr_val_d;
            cnt_q       <= cnt_d;
            cs_q        <= cs_d;
            we_q        <= we_d;
            din_q       <= din_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            busy_q      <= busy_d;
        end
    end

endmodule

// File: doc/stencil_access_ctrl.md
Name: stencil_access_ctrl

Overview:
- Client-side controller that owns both ports of the 1-bit x 16K synchronous stencil/mask RAM (sync write port, sync read port, shared cs/we).
- Turns single-bit read, write and test-and-set requests from the GPU pixel pipeline into correctly sequenced RAM cycles, with one-cycle read latency.
- Also runs a bulk clear sequencer that sweeps every address with a fixed value.

Parameters:
ADDR_W, 14, RAM address width; depth = 2^ADDR_W entries.

Ports:
clk  in  1  system clock; all logic on rising edge
nRst  in  1  asynchronous active-low reset
req_valid  in  1  request present
req_ready  out  1  controller can accept a request this cycle
req_op  in  2  00 read, 01 write, 10 test-and-set, 11 reserved (treated as read)
req_addr  in  ADDR_W  bit address
req_data  in  1  write data (op 01 only)
rsp_valid  out  1  one-cycle pulse, response for the oldest accepted request
rsp_data  out  1  old bit value (read/TAS); 0 for write
clear_start  in  1  pulse: begin bulk clear
clear_value  in  1  value written by the clear, sampled with clear_start
clear_busy  out  1  clear in progress
ram_addrIn  out  ADDR_W  RAM write address
ram_addrOut  out  ADDR_W  RAM read address
ram_dataIn  out  1  RAM write data
ram_dataOut  in  1  RAM read data, valid the cycle after a read edge
ram_cs  out  1  RAM chip select
ram_we  out  1  RAM write enable (1 = write, 0 = read when cs=1)

Behaviour:
- Reset, async on nRst low: state=IDLE, all RAM outputs 0, rsp_valid=0, rsp_data=0, clear_busy=0, req_ready=0.
- Outputs after reset: req_ready=1 from the first IDLE cycle after release.
- Output timing: all ram_* outputs and rsp_* are registered; req_ready = (state==IDLE) is combinational from state.
- States: IDLE, WR, RD, CAP, TASW, CLR.
- IDLE: a request is accepted on an edge E0 with req_valid&req_ready; req_addr, req_op and req_data are latched.
  - clear_start high on the same edge wins: the request is not accepted, and the client must hold it.
- Write, E0 -> WR: ram_cs=1, ram_we=1, ram_addrIn=addr, ram_dataIn=req_data. The RAM writes at E1.
  - At E1 -> IDLE, rsp_valid=1, rsp_data=0. One request per 2 cycles.
- Read, E0 -> RD: ram_cs=1, ram_we=0, ram_addrOut=addr. The RAM reads at E1.
  - E1 -> CAP: cs=0.
  - At E2: rsp_valid=1, rsp_data=ram_dataOut; -> IDLE. One request per 3 cycles.
- Test-and-set: same as read through E2.
  - At E2 -> TASW: rsp_valid=1, rsp_data=old bit; ram_cs=1, ram_we=1, addrIn=addr, dataIn=1.
  - The RAM writes at E3 -> IDLE. Atomic: no request is accepted until the write completes.
- Inactive RAM outputs: whenever not in an active RAM cycle, ram_cs=0 and ram_we=0. addrIn and addrOut always carry the same latched address; no read and write are ever issued in the same cycle.
- Clear, on IDLE & clear_start:
  - On entry: value latched; counter=0; -> CLR; clear_busy=1.
  - Each CLR cycle: cs=1, we=1, addrIn=counter, dataIn=value; counter+1.
  - After address 2^ADDR_W-1 is written (edge 2^ADDR_W after start): state -> IDLE, clear_busy=0, cs=we=0.
  - Total busy = 2^ADDR_W cycles. The counter is ADDR_W+1 bits, so there is no premature wrap. No rsp_valid pulse.
- clear_start outside IDLE is ignored, including during CLR.
- req_valid while not ready: no effect; the request must be held stable by the client until accepted.
- Reset mid-operation: any in-flight RAM write is abandoned, cs/we drop immediately (async), and no response is issued. RAM contents are undefined for an aborted TAS or clear.

Test Plan:
- Reset release -> all outputs 0; req_ready=1 on the first cycle after nRst rises; ram_cs=0.
- Write addr 0x1234 data 1, then read 0x1234 -> WR cycle shows cs=1, we=1, addrIn=0x1234; read rsp_valid exactly 2 cycles after accept with rsp_data=1; req_ready low for 2 cycles.
- Test-and-set 0x0005 twice (bit initially 0) -> first rsp_data=0, second rsp_data=1; write cycle has dataIn=1; no accept during RD/CAP/TASW.
- clear_start with clear_value=1 -> clear_busy high exactly 16384 cycles; addrIn sequences 0..0x3FFF; random reads afterwards return 1.
- clear_start and req_valid on the same IDLE edge -> clear starts; request accepted on the first IDLE cycle after busy drops.
- nRst asserted in the middle of a clear (counter=0x0100) -> cs/we/clear_busy low immediately; after release, state is IDLE and req_ready=1.
